// File: rtl/tia_scan_capture.sv
// TIA scan capture: turns the TIA HBLANK/VBLANK/COLOROUT stream into {x, y, color} pixel
// entries and buffers them in a show-ahead FIFO drained through a valid/ready port.
`timescale 1ns/1ps
module tia_scan_capture #(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned X_VISIBLE  = 160,
    parameter int unsigned Y_MAX      = 511
) (
    input  logic                  CLOCKPIXEL,
    input  logic                  RES_n,
    input  logic                  HBLANK,
    input  logic                  VBLANK,
    input  logic [7:0]            COLOROUT,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [7:0]            pix_x,
    output logic [8:0]            pix_y,
    output logic [7:0]            pix_color,
    output logic                  frame_start,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           overflow_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned EW    = 25;

    localparam logic [8:0]            X_VIS      = X_VISIBLE[8:0];
    localparam logic [8:0]            Y_SAT      = Y_MAX[8:0];
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_VBLANK,
        S_HBLANK,
        S_ACTIVE
    } state_t;

    // Input stage
    logic       hb_r, hb_rr, vb_r;
    logic [7:0] col_r;

    // Scan FSM and coordinates
    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       line_hit_q, line_hit_d;
    logic       armed_q, armed_d;
    logic       fs_q, fs_d;
    logic       push_req;

    // FIFO
    logic [EW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  valid_q, valid_d;
    logic [EW-1:0]         head_q, head_d;
    logic [15:0]           ovf_q, ovf_d;
    logic                  pop, push_ok, drop, full;
    logic [DEPTH_LOG2-1:0] rd_next;
    logic                  head_avail;

    always_ff @(posedge CLOCKPIXEL or negedge RES_n) begin
        if (!RES_n) begin
            hb_r  <= 1'b0;
            hb_rr <= 1'b0;
            vb_r  <= 1'b0;
            col_r <= 8'd0;
        end else begin
            hb_r  <= HBLANK;
            hb_rr <= hb_r;
            vb_r  <= VBLANK;
            col_r <= COLOROUT;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        line_hit_d = line_hit_q;
        armed_d    = armed_q | vb_r;
        fs_d       = 1'b0;
        push_req   = 1'b0;
        unique case (state_q)
            S_VBLANK: begin
                x_d = 8'd0;
                y_d = 9'd0;
                // Only a genuine VBLANK falling edge starts a frame, so a reset
                // taken mid-frame waits for the next vertical blank.
                if (!vb_r && armed_q) begin
                    state_d = S_HBLANK;
                    fs_d    = 1'b1;
                    armed_d = 1'b0;
                end
            end
            S_HBLANK: begin
                x_d = 8'd0;
                if (vb_r) begin
                    state_d = S_VBLANK;
                    y_d     = 9'd0;
                end else if (!hb_r) begin
                    // First visible sample is captured on the transition itself.
                    state_d  = S_ACTIVE;
                    push_req = (X_VIS != 9'd0);
                    x_d      = 8'd1;
                end
            end
            S_ACTIVE: begin
                if (vb_r) begin
                    state_d = S_VBLANK;
                    x_d     = 8'd0;
                    y_d     = 9'd0;
                end else if (hb_r) begin
                    state_d = S_HBLANK;
                    x_d     = 8'd0;
                    if (line_hit_q && (y_q < Y_SAT)) begin
                        y_d = y_q + 9'd1;
                    end
                end else begin
                    push_req = ({1'b0, x_q} < X_VIS);
                    if (x_q != 8'hFF) begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            default: state_d = S_VBLANK;
        endcase
        line_hit_d = line_hit_d | push_req;
        // Start-of-blank clears the per-line flag after y has used it.
        if (vb_r || (hb_r && !hb_rr)) begin
            line_hit_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCKPIXEL or negedge RES_n) begin
        if (!RES_n) begin
            state_q    <= S_VBLANK;
            x_q        <= 8'd0;
            y_q        <= 9'd0;
            line_hit_q <= 1'b0;
            armed_q    <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            line_hit_q <= line_hit_d;
            armed_q    <= armed_d;
            fs_q       <= fs_d;
        end
    end

    always_comb begin
        pop     = valid_q & pix_ready;
        full    = (level_q == LEVEL_FULL);
        push_ok = push_req & (~full | pop);
        drop    = push_req & full & ~pop;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        level_d = level_q;
        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // The head register mirrors mem[rd_ptr]; refill it from entries already
        // in memory, so an entry written this edge appears one edge later.
        rd_next    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        head_avail = pop ? (level_q > LEVEL_ONE) : (level_q != '0);
        valid_d    = valid_q;
        head_d     = head_q;
        if (!valid_q || pop) begin
            valid_d = head_avail;
            if (head_avail) begin
                head_d = mem[rd_next];
            end
        end

        ovf_d = ovf_q;
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCKPIXEL) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {x_q, y_q, col_r};
        end
    end

    always_ff @(posedge CLOCKPIXEL or negedge RES_n) begin
        if (!RES_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            ovf_q    <= 16'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    assign pix_valid    = valid_q;
    assign pix_x        = head_q[24:17];
    assign pix_y        = head_q[16:8];
    assign pix_color    = head_q[7:0];
    assign frame_start  = fs_q;
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_tia_scan_capture.sv
// Bench for tia_scan_capture: line tables, overflow, backpressure and mid-line reset, with a
// queue scoreboard checked whenever the DUT hands over an entry.
`timescale 1ns/1ps
module tb_tia_scan_capture;

    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hblank = 1'b0;
    logic          vblank = 1'b0;
    logic [7:0]    colorout = 8'd0;
    logic          pix_ready = 1'b0;
    logic          pix_valid;
    logic [7:0]    pix_x;
    logic [8:0]    pix_y;
    logic [7:0]    pix_color;
    logic          frame_start;
    logic [DL:0]   fifo_level;
    logic [15:0]   overflow_cnt;

    tia_scan_capture #(
        .DEPTH_LOG2 (DL),
        .X_VISIBLE  (160),
        .Y_MAX      (511)
    ) dut (
        .CLOCKPIXEL   (clk),
        .RES_n        (rst_n),
        .HBLANK       (hblank),
        .VBLANK       (vblank),
        .COLOROUT     (colorout),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_color    (pix_color),
        .frame_start  (frame_start),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [8:0] y;
        logic [7:0] c;
    } entry_t;

    typedef struct {
        int n_active;
        bit toggle;
        int exp_pops;
    } line_vec_t;

    entry_t    exp_q[$];
    line_vec_t lines[5];
    int        n_vec = 0;
    int        n_err = 0;
    int        exp_y = 0;
    int        line_pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer side: an entry is taken at the next rising edge when valid & ready.
    logic   prev_hold = 1'b0;
    entry_t prev_e;
    entry_t got_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                check("hold_while_not_ready", {pix_valid, pix_x, pix_y, pix_color},
                      {1'b1, prev_e});
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_entry", {pix_x, pix_y, pix_color}, 32'hFFFF_FFFF);
                end else begin
                    got_e = exp_q.pop_front();
                    check("entry", {pix_x, pix_y, pix_color}, got_e);
                    line_pops++;
                end
            end
            prev_hold = pix_valid && !pix_ready;
            prev_e    = {pix_x, pix_y, pix_color};
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic start_frame();
        vblank = 1'b1;
        hblank = 1'b1;
        repeat (3) tick();
        vblank = 1'b0;
        tick();
        check("frame_start_early", frame_start, 0);
        tick();
        check("frame_start_pulse", frame_start, 1);
        tick();
        check("frame_start_one_cycle", frame_start, 0);
        exp_y = 0;
    endtask

    task automatic run_line(input int n, input int hb, input bit toggle);
        hblank = 1'b1;
        repeat (hb) tick();
        for (int i = 0; i < n; i++) begin
            hblank   = 1'b0;
            colorout = i[7:0];
            if (toggle) pix_ready = ~pix_ready;
            if (i < 160) exp_q.push_back({i[7:0], exp_y[8:0], i[7:0]});
            tick();
        end
        hblank = 1'b1;
        if (n > 0) exp_y++;
    endtask

    initial begin
        lines[0] = '{n_active: 160, toggle: 1'b0, exp_pops: 160};
        lines[1] = '{n_active: 160, toggle: 1'b0, exp_pops: 160};
        lines[2] = '{n_active: 160, toggle: 1'b0, exp_pops: 160};
        lines[3] = '{n_active: 200, toggle: 1'b0, exp_pops: 160};
        lines[4] = '{n_active: 24,  toggle: 1'b1, exp_pops: 24};

        repeat (3) tick();
        check("rst_valid", pix_valid, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_color", pix_color, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow_cnt, 0);
        rst_n = 1'b1;

        start_frame();
        for (int k = 0; k < 5; k++) begin
            line_pops = 0;
            pix_ready = 1'b1;
            run_line(lines[k].n_active, 10, lines[k].toggle);
            pix_ready = 1'b1;
            repeat (40) tick();
            check("line_pops", line_pops, lines[k].exp_pops);
            check("line_drained", exp_q.size(), 0);
            check("line_level", fifo_level, 0);
            check("line_overflow", overflow_cnt, 0);
        end

        // Overflow: 20 pixels into a 16-entry FIFO with the consumer stalled.
        line_pops = 0;
        pix_ready = 1'b0;
        run_line(20, 10, 1'b0);
        repeat (4) void'(exp_q.pop_back());
        repeat (5) tick();
        check("ovf_level", fifo_level, 16);
        check("ovf_count", overflow_cnt, 4);
        check("ovf_head_valid", pix_valid, 1);
        check("ovf_head_x", pix_x, 0);
        check("ovf_head_y", pix_y, exp_y - 1);
        check("ovf_head_color", pix_color, 0);

        // Full FIFO with push and pop on the same edge.
        hblank   = 1'b0;
        colorout = 8'h5A;
        tick();
        pix_ready = 1'b1;
        hblank    = 1'b1;
        exp_q.push_back({8'd0, exp_y[8:0], 8'h5A});
        exp_y++;
        tick();
        pix_ready = 1'b0;
        check("full_pushpop_level", fifo_level, 16);
        check("full_pushpop_overflow", overflow_cnt, 4);
        pix_ready = 1'b1;
        repeat (40) tick();
        check("ovf_pops", line_pops, 17);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_level_empty", fifo_level, 0);

        // Asynchronous reset in the middle of a line.
        line_pops = 0;
        pix_ready = 1'b1;
        hblank    = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 160; i++) begin
            hblank   = 1'b0;
            colorout = i[7:0];
            if (i == 82) begin
                check("pre_reset_pops", line_pops, 79);
                rst_n = 1'b0;
                #1;
                check("async_rst_valid", pix_valid, 0);
                check("async_rst_level", fifo_level, 0);
                check("async_rst_overflow", overflow_cnt, 0);
                exp_q.delete();
                #2;
                rst_n = 1'b1;
            end else if (i < 82) begin
                exp_q.push_back({i[7:0], exp_y[8:0], i[7:0]});
            end
            tick();
        end
        hblank = 1'b1;
        repeat (20) tick();
        check("post_rst_level", fifo_level, 0);
        check("post_rst_valid", pix_valid, 0);

        line_pops = 0;
        start_frame();
        run_line(160, 10, 1'b0);
        repeat (40) tick();
        check("restart_pops", line_pops, 160);
        check("restart_drained", exp_q.size(), 0);
        check("restart_level", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
